vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered blank, sync and
// line/frame strobes. All outputs are decoded from the next raster position and
// registered together, so they describe the same pixel in the same cycle.
module vga_timing_gen #(
  parameter int unsigned p_H_VISIBLE   = 640,
  parameter int unsigned p_H_FRONT     = 16,
  parameter int unsigned p_H_SYNC      = 96,
  parameter int unsigned p_H_BACK      = 48,
  parameter int unsigned p_V_VISIBLE   = 480,
  parameter int unsigned p_V_FRONT     = 10,
  parameter int unsigned p_V_SYNC      = 2,
  parameter int unsigned p_V_BACK      = 33,
  parameter bit          p_SYNC_ACTIVE = 1'b0
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Enable,
  output logic [9:0] o_HPos,
  output logic [9:0] o_VPos,
  output logic       o_HBlank,
  output logic       o_VBlank,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_HReset,
  output logic       o_VReset,
  output logic [7:0] o_Frame
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CMP_W   = CNT_W + 1;
  localparam int unsigned FRAME_W = 8;
  localparam int unsigned CNT_MAX = 1 << CNT_W;

  localparam int unsigned H_TOTAL = p_H_VISIBLE + p_H_FRONT + p_H_SYNC + p_H_BACK;
  localparam int unsigned V_TOTAL = p_V_VISIBLE + p_V_FRONT + p_V_SYNC + p_V_BACK;
  localparam int unsigned H_LAST  = H_TOTAL - 1;
  localparam int unsigned V_LAST  = V_TOTAL - 1;

  // Sync windows as half-open ranges [start, stop); compared one bit wider so a
  // window ending exactly at the counter limit still decodes correctly.
  localparam int unsigned HS_START = p_H_VISIBLE + p_H_FRONT;
  localparam int unsigned HS_STOP  = HS_START + p_H_SYNC;
  localparam int unsigned VS_START = p_V_VISIBLE + p_V_FRONT;
  localparam int unsigned VS_STOP  = VS_START + p_V_SYNC;

  // Elaboration guard: totals must fit the 10-bit counters and be non-empty.
  if (H_TOTAL == 0 || H_TOTAL > CNT_MAX) begin : g_h_total_range
    $error("vga_timing_gen: horizontal total %0d outside 1..%0d", H_TOTAL, CNT_MAX);
  end
  if (V_TOTAL == 0 || V_TOTAL > CNT_MAX) begin : g_v_total_range
    $error("vga_timing_gen: vertical total %0d outside 1..%0d", V_TOTAL, CNT_MAX);
  end

  logic [CNT_W-1:0]   h_nxt;
  logic [CNT_W-1:0]   v_nxt;
  logic [FRAME_W-1:0] frame_nxt;
  logic               hblank_nxt;
  logic               vblank_nxt;
  logic               hsync_nxt;
  logic               vsync_nxt;
  logic               hreset_nxt;
  logic               vreset_nxt;

  // Next raster position: column wraps every line, line and frame advance on the wrap.
  always_comb begin
    h_nxt     = o_HPos;
    v_nxt     = o_VPos;
    frame_nxt = o_Frame;
    if (o_HPos == CNT_W'(H_LAST)) begin
      h_nxt = '0;
      if (o_VPos == CNT_W'(V_LAST)) begin
        v_nxt     = '0;
        frame_nxt = o_Frame + FRAME_W'(1);
      end else begin
        v_nxt = o_VPos + CNT_W'(1);
      end
    end else begin
      h_nxt = o_HPos + CNT_W'(1);
    end
  end

  // Decode of the next position so registered flags line up with registered counters.
  always_comb begin
    hblank_nxt = ({1'b0, h_nxt} >= CMP_W'(p_H_VISIBLE));
    vblank_nxt = ({1'b0, v_nxt} >= CMP_W'(p_V_VISIBLE));
    hsync_nxt  = ~p_SYNC_ACTIVE;
    vsync_nxt  = ~p_SYNC_ACTIVE;
    if (({1'b0, h_nxt} >= CMP_W'(HS_START)) && ({1'b0, h_nxt} < CMP_W'(HS_STOP))) begin
      hsync_nxt = p_SYNC_ACTIVE;
    end
    if (({1'b0, v_nxt} >= CMP_W'(VS_START)) && ({1'b0, v_nxt} < CMP_W'(VS_STOP))) begin
      vsync_nxt = p_SYNC_ACTIVE;
    end
    hreset_nxt = (h_nxt == CNT_W'(H_LAST));
    vreset_nxt = hreset_nxt && (v_nxt == CNT_W'(V_LAST));
  end

  // Raster state and outputs; enable low freezes everything including strobes.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_HPos   <= '0;
      o_VPos   <= '0;
      o_Frame  <= '0;
      o_HBlank <= 1'b0;
      o_VBlank <= 1'b0;
      o_HSync  <= ~p_SYNC_ACTIVE;
      o_VSync  <= ~p_SYNC_ACTIVE;
      o_HReset <= 1'b0;
      o_VReset <= 1'b0;
    end else if (i_Enable) begin
      o_HPos   <= h_nxt;
      o_VPos   <= v_nxt;
      o_Frame  <= frame_nxt;
      o_HBlank <= hblank_nxt;
      o_VBlank <= vblank_nxt;
      o_HSync  <= hsync_nxt;
      o_VSync  <= vsync_nxt;
      o_HReset <= hreset_nxt;
      o_VReset <= vreset_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, inverted-sync and small-raster instances
// checked every cycle against a pixel-index model through expectation queues.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hb;
    logic       vb;
    logic       hs;
    logic       vs;
    logic       hr;
    logic       vr;
    logic [7:0] fr;
  } obs_t;

  localparam int A_FRAME = 800 * 525;
  localparam int S_FRAME = 14 * 7;

  logic clk;
  logic rst_n, en, rst_s, en_s;

  logic [9:0] a_h, a_v, b_h, b_v, s_h, s_v;
  logic a_hb, a_vb, a_hs, a_vs, a_hr, a_vr;
  logic b_hb, b_vb, b_hs, b_vs, b_hr, b_vr;
  logic s_hb, s_vb, s_hs, s_vs, s_hr, s_vr;
  logic [7:0] a_fr, b_fr, s_fr;

  obs_t oa, ob, os;
  assign oa = {a_h, a_v, a_hb, a_vb, a_hs, a_vs, a_hr, a_vr, a_fr};
  assign ob = {b_h, b_v, b_hb, b_vb, b_hs, b_vs, b_hr, b_vr, b_fr};
  assign os = {s_h, s_v, s_hb, s_vb, s_hs, s_vs, s_hr, s_vr, s_fr};

  vga_timing_gen dut_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en),
    .o_HPos(a_h), .o_VPos(a_v), .o_HBlank(a_hb), .o_VBlank(a_vb),
    .o_HSync(a_hs), .o_VSync(a_vs), .o_HReset(a_hr), .o_VReset(a_vr), .o_Frame(a_fr)
  );

  vga_timing_gen #(.p_SYNC_ACTIVE(1'b1)) dut_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en),
    .o_HPos(b_h), .o_VPos(b_v), .o_HBlank(b_hb), .o_VBlank(b_vb),
    .o_HSync(b_hs), .o_VSync(b_vs), .o_HReset(b_hr), .o_VReset(b_vr), .o_Frame(b_fr)
  );

  vga_timing_gen #(
    .p_H_VISIBLE(8), .p_H_FRONT(2), .p_H_SYNC(2), .p_H_BACK(2),
    .p_V_VISIBLE(4), .p_V_FRONT(1), .p_V_SYNC(1), .p_V_BACK(1)
  ) dut_s (
    .i_Clk(clk), .i_Rst_n(rst_s), .i_Enable(en_s),
    .o_HPos(s_h), .o_VPos(s_v), .o_HBlank(s_hb), .o_VBlank(s_vb),
    .o_HSync(s_hs), .o_VSync(s_vs), .o_HReset(s_hr), .o_VReset(s_vr), .o_Frame(s_fr)
  );

  int    n_checks, n_err;
  int    sb_bad;
  string sb_first;
  int    ta, fa, ts, fs;
  obs_t  qa[$], qb[$], qs[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "timeout");
  end

  // Expected outputs for pixel index t (0..H_TOTAL*V_TOTAL-1) within frame fr.
  function automatic obs_t calc(input int t, input int fr,
                                input int hv, input int hf, input int hsw, input int hbp,
                                input int vv, input int vf, input int vsw, input int vbp,
                                input bit act);
    obs_t o;
    int ht, vt, h, v;
    ht = hv + hf + hsw + hbp;
    vt = vv + vf + vsw + vbp;
    h = t % ht;
    v = t / ht;
    o.h  = 10'(h);
    o.v  = 10'(v);
    o.hb = (h >= hv);
    o.vb = (v >= vv);
    o.hs = (h >= hv + hf && h < hv + hf + hsw) ? act : ~act;
    o.vs = (v >= vv + vf && v < vv + vf + vsw) ? act : ~act;
    o.hr = (h == ht - 1);
    o.vr = (t == ht * vt - 1);
    o.fr = 8'(fr);
    return o;
  endfunction

  function automatic obs_t exp_a(input int t, input int fr);
    return calc(t, fr, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
  endfunction

  function automatic obs_t exp_b(input int t, input int fr);
    return calc(t, fr, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1);
  endfunction

  function automatic obs_t exp_s(input int t, input int fr);
    return calc(t, fr, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0);
  endfunction

  // One clock: advance the models, queue expectations, then pop and compare after the edge.
  task automatic tick();
    obs_t ea, eb, es;
    @(posedge clk);
    if (!rst_n) begin
      ta = 0; fa = 0;
    end else if (en) begin
      ta++;
      if (ta == A_FRAME) begin ta = 0; fa = (fa + 1) % 256; end
    end
    if (!rst_s) begin
      ts = 0; fs = 0;
    end else if (en_s) begin
      ts++;
      if (ts == S_FRAME) begin ts = 0; fs = (fs + 1) % 256; end
    end
    qa.push_back(exp_a(ta, fa));
    qb.push_back(exp_b(ta, fa));
    qs.push_back(exp_s(ts, fs));
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    es = qs.pop_front();
    if (oa !== ea) begin
      sb_bad++;
      if (sb_first == "") sb_first = $sformatf("dflt t=%0d got %h want %h", ta, oa, ea);
    end
    if (ob !== eb) begin
      sb_bad++;
      if (sb_first == "") sb_first = $sformatf("inv t=%0d got %h want %h", ta, ob, eb);
    end
    if (os !== es) begin
      sb_bad++;
      if (sb_first == "") sb_first = $sformatf("small t=%0d got %h want %h", ts, os, es);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; rst_s = 1'b1; en = 1'b1; en_s = 1'b1;
    #2;
    rst_n = 1'b0; rst_s = 1'b0;
    #1;
    ta = 0; fa = 0; ts = 0; fs = 0;
    n_checks++;
    if (oa !== exp_a(0, 0)) begin
      n_err++; $display("FAIL reset_default: got %h want %h", oa, exp_a(0, 0));
    end
    sb_bad = 0; sb_first = "";
    repeat (3) tick();
    n_checks++;
    if (ob !== exp_b(0, 0)) begin
      n_err++; $display("FAIL reset_inverted: got %h want %h", ob, exp_b(0, 0));
    end
    n_checks++;
    if (os !== exp_s(0, 0)) begin
      n_err++; $display("FAIL reset_small: got %h want %h", os, exp_s(0, 0));
    end
  endtask

  task automatic test_line();
    int hs_lo, hs_hi_b, rise_h, hr_n, hr_h, first_hr, edges;
    logic prev_hb;
    hs_lo = 0; hs_hi_b = 0; rise_h = -1; hr_n = 0; hr_h = -1; first_hr = -1; edges = 0;
    sb_bad = 0; sb_first = "";
    prev_hb = oa.hb;
    rst_n = 1'b1;
    repeat (801) begin
      tick();
      edges++;
      if (oa.hs === 1'b0) hs_lo++;
      if (ob.hs === 1'b1) hs_hi_b++;
      if (prev_hb === 1'b0 && oa.hb === 1'b1 && rise_h < 0) rise_h = int'(oa.h);
      prev_hb = oa.hb;
      if (oa.hr === 1'b1) begin
        hr_n++; hr_h = int'(oa.h);
        if (first_hr < 0) first_hr = edges;
      end
    end
    n_checks++;
    if (sb_bad !== 0) begin n_err++; $display("FAIL line_scoreboard: bad=%0d want 0 (%s)", sb_bad, sb_first); end
    n_checks++;
    if (hs_lo !== 96) begin n_err++; $display("FAIL line_hsync_width: got %0d want 96", hs_lo); end
    n_checks++;
    if (hs_hi_b !== 96) begin n_err++; $display("FAIL line_hsync_inverted_width: got %0d want 96", hs_hi_b); end
    n_checks++;
    if (rise_h !== 640) begin n_err++; $display("FAIL line_hblank_rise: got %0d want 640", rise_h); end
    n_checks++;
    if (hr_n !== 1 || hr_h !== 799) begin
      n_err++; $display("FAIL line_hreset: count=%0d at=%0d want 1 at 799", hr_n, hr_h);
    end
    n_checks++;
    if (first_hr !== 799) begin n_err++; $display("FAIL line_first_hreset_latency: got %0d want 799", first_hr); end
    n_checks++;
    if (oa.h !== 10'd1 || oa.v !== 10'd1) begin
      n_err++; $display("FAIL line_wrap_pos: got (%0d,%0d) want (1,1)", oa.h, oa.v);
    end
  endtask

  task automatic test_frame_small();
    int hr_n, vr_n, vr_h, vr_v, vb_n, vs_lo, hs_lo, viol;
    hr_n = 0; vr_n = 0; vr_h = -1; vr_v = -1; vb_n = 0; vs_lo = 0; hs_lo = 0; viol = 0;
    sb_bad = 0; sb_first = "";
    rst_s = 1'b1;
    repeat (S_FRAME) begin
      tick();
      if (os.hr === 1'b1) hr_n++;
      if (os.vr === 1'b1) begin vr_n++; vr_h = int'(os.h); vr_v = int'(os.v); end
      if (os.vb === 1'b1) vb_n++;
      if (os.vs === 1'b0) vs_lo++;
      if (os.hs === 1'b0) hs_lo++;
      if (os.vr === 1'b1 && !(os.hr === 1'b1 && os.hb === 1'b1 && os.vb === 1'b1)) viol++;
      if (os.hr === 1'b1 && os.hb !== 1'b1) viol++;
    end
    n_checks++;
    if (sb_bad !== 0) begin n_err++; $display("FAIL small_scoreboard: bad=%0d want 0 (%s)", sb_bad, sb_first); end
    n_checks++;
    if (hr_n !== 7) begin n_err++; $display("FAIL small_hreset_count: got %0d want 7", hr_n); end
    n_checks++;
    if (vr_n !== 1 || vr_h !== 13 || vr_v !== 6) begin
      n_err++; $display("FAIL small_vreset: count=%0d at (%0d,%0d) want 1 at (13,6)", vr_n, vr_h, vr_v);
    end
    n_checks++;
    if (vb_n !== 42) begin n_err++; $display("FAIL small_vblank_cycles: got %0d want 42", vb_n); end
    n_checks++;
    if (vs_lo !== 14) begin n_err++; $display("FAIL small_vsync_cycles: got %0d want 14", vs_lo); end
    n_checks++;
    if (hs_lo !== 14) begin n_err++; $display("FAIL small_hsync_cycles: got %0d want 14", hs_lo); end
    n_checks++;
    if (viol !== 0) begin n_err++; $display("FAIL small_strobe_alignment: got %0d want 0", viol); end
    n_checks++;
    if (os.fr !== 8'd1 || os.h !== 10'd0 || os.v !== 10'd0) begin
      n_err++; $display("FAIL small_frame_step: got fr=%0d (%0d,%0d) want fr=1 (0,0)", os.fr, os.h, os.v);
    end
  endtask

  task automatic test_frame_wrap();
    int vr_n;
    bit saw_wrap;
    logic [7:0] prev_fr;
    vr_n = 0; saw_wrap = 1'b0;
    sb_bad = 0; sb_first = "";
    prev_fr = os.fr;
    repeat (256 * S_FRAME) begin
      tick();
      if (os.vr === 1'b1) vr_n++;
      if (prev_fr === 8'd255 && os.fr === 8'd0) saw_wrap = 1'b1;
      prev_fr = os.fr;
    end
    n_checks++;
    if (sb_bad !== 0) begin n_err++; $display("FAIL wrap_scoreboard: bad=%0d want 0 (%s)", sb_bad, sb_first); end
    n_checks++;
    if (vr_n !== 256) begin n_err++; $display("FAIL wrap_vreset_count: got %0d want 256", vr_n); end
    n_checks++;
    if (saw_wrap !== 1'b1) begin n_err++; $display("FAIL wrap_frame_255_to_0: got %0d want 1", saw_wrap); end
  endtask

  task automatic test_enable();
    int edges, vr_cnt, hold_bad;
    bit froze;
    logic [7:0] fr_start;
    obs_t hold_exp;
    edges = 0; vr_cnt = 0; hold_bad = 0; froze = 1'b0;
    sb_bad = 0; sb_first = "";
    for (int k = 0; k < 2 * S_FRAME && ts != 0; k++) tick();
    fr_start = os.fr;
    for (int k = 0; k < 300; k++) begin
      if (os.fr !== fr_start) break;
      if (!froze && ts == S_FRAME - 2) begin
        hold_exp = exp_s(ts, fs);
        en_s = 1'b0;
        repeat (37) begin
          tick();
          if (os !== hold_exp) hold_bad++;
        end
        en_s = 1'b1;
        froze = 1'b1;
        tick();
        edges++;
        if (os.vr === 1'b1) vr_cnt++;
        n_checks++;
        if (!(os.vr === 1'b1 && os.h === 10'd13 && os.v === 10'd6)) begin
          n_err++; $display("FAIL enable_resume_vreset: got vr=%b (%0d,%0d) want 1 (13,6)", os.vr, os.h, os.v);
        end
      end else begin
        tick();
        edges++;
        if (os.vr === 1'b1) vr_cnt++;
      end
    end
    n_checks++;
    if (hold_bad !== 0) begin n_err++; $display("FAIL enable_hold: bad cycles=%0d want 0", hold_bad); end
    n_checks++;
    if (edges !== S_FRAME) begin n_err++; $display("FAIL enable_frame_length: got %0d want %0d", edges, S_FRAME); end
    n_checks++;
    if (vr_cnt !== 1) begin n_err++; $display("FAIL enable_vreset_once: got %0d want 1", vr_cnt); end
    n_checks++;
    if (sb_bad !== 0) begin n_err++; $display("FAIL enable_scoreboard: bad=%0d want 0 (%s)", sb_bad, sb_first); end
  endtask

  task automatic test_strobe_hold();
    int hi;
    hi = 0;
    for (int k = 0; k < 2 * S_FRAME && ts != S_FRAME - 1; k++) tick();
    en_s = 1'b0;
    repeat (5) begin
      tick();
      if (os.vr === 1'b1 && os.hr === 1'b1) hi++;
    end
    en_s = 1'b1;
    n_checks++;
    if (hi !== 5) begin n_err++; $display("FAIL strobe_held_when_frozen: got %0d want 5", hi); end
    tick();
    n_checks++;
    if (os.vr !== 1'b0 || os.h !== 10'd0 || os.v !== 10'd0) begin
      n_err++; $display("FAIL strobe_release: got vr=%b (%0d,%0d) want 0 (0,0)", os.vr, os.h, os.v);
    end
  endtask

  task automatic test_async_reset();
    sb_bad = 0; sb_first = "";
    for (int k = 0; k < 2 * S_FRAME && ts != 4 * 14 + 9; k++) tick();
    #3;
    rst_s = 1'b0;
    #1;
    n_checks++;
    if (os !== exp_s(0, 0)) begin
      n_err++; $display("FAIL async_reset_immediate: got %h want %h", os, exp_s(0, 0));
    end
    ts = 0; fs = 0;
    repeat (2) tick();
    rst_s = 1'b1;
    tick();
    n_checks++;
    if (os.h !== 10'd1 || os.v !== 10'd0 || os.hr !== 1'b0) begin
      n_err++; $display("FAIL async_reset_restart: got (%0d,%0d) hr=%b want (1,0) hr=0", os.h, os.v, os.hr);
    end
    repeat (30) tick();
    n_checks++;
    if (sb_bad !== 0) begin n_err++; $display("FAIL async_reset_scoreboard: bad=%0d want 0 (%s)", sb_bad, sb_first); end
  endtask

  initial begin
    n_checks = 0; n_err = 0; sb_bad = 0; sb_first = "";
    test_reset();
    test_line();
    test_frame_small();
    test_frame_wrap();
    test_enable();
    test_strobe_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
